// File: rtl/ps2_scan_decoder_if.sv
// Key-event stream from the PS/2 decoder: head-of-FIFO event with valid/ready handshake.
interface ps2_scan_decoder_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;

  modport master (output ev_valid, ev_code, ev_ext, ev_brk, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_ext, ev_brk, output ev_ready);
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: tick-sampled frame assembly, E0/F0 prefix folding, event FIFO.
// Define PS2_GLITCH_FILTER_EN to require 4 stable ticks before the sampled PS2_CLK changes.
module ps2_scan_decoder #(
  parameter int unsigned SAMPLE_DIV    = 250,
  parameter int unsigned TIMEOUT_TICKS = 4000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PS2_CLK,
  input  logic               PS2_DATA,
  ps2_scan_decoder_if.master ev,
  output logic               frame_err,
  output logic               overflow,
  output logic               busy
);
  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

  logic            clk_s1, clk_s2, dat_s1, dat_s2;
  logic [DivW-1:0] div_q;
  logic            tick_q;
  logic            edge_clk, prev_clk_q, fall;
  state_e          state_q;
  logic [10:0]     shift_q;
  logic [3:0]      cnt_q;
  logic [TmoW-1:0] tmo_q;
  logic            ext_q, brk_q;
  logic            frame_ok, push;
  logic [7:0]      code;

  logic [9:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [PtrW:0]   count_q;
  logic            full, pop, do_push;

  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DATA;
      dat_s2 <= dat_s1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else if (div_q == DivW'(SAMPLE_DIV - 1)) begin
      div_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      div_q  <= div_q + DivW'(1);
      tick_q <= 1'b0;
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  logic       filt_q;
  logic [1:0] run_q;

  // run_q counts consecutive ticks disagreeing with filt_q; the 4th flips it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_q <= 1'b1;
      run_q  <= '0;
    end else if (tick_q) begin
      if (clk_s2 == filt_q) begin
        run_q <= '0;
      end else if (run_q == 2'd3) begin
        filt_q <= clk_s2;
        run_q  <= '0;
      end else begin
        run_q <= run_q + 2'd1;
      end
    end
  end

  assign edge_clk = filt_q;
`else
  assign edge_clk = clk_s2;
`endif

  assign fall     = tick_q & prev_clk_q & ~edge_clk;
  assign code     = shift_q[8:1];
  assign frame_ok = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);
  assign push     = tick_q && (state_q == StCheck) && frame_ok &&
                    (code != 8'hE0) && (code != 8'hF0);
  assign busy     = (state_q == StRecv);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      prev_clk_q <= 1'b1;
      shift_q    <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (tick_q) begin
        prev_clk_q <= edge_clk;
        case (state_q)
          StIdle: begin
            if (fall) begin
              shift_q <= {dat_s2, shift_q[10:1]};
              cnt_q   <= 4'd1;
              tmo_q   <= '0;
              state_q <= StRecv;
            end
          end
          StRecv: begin
            tmo_q <= tmo_q + TmoW'(1);
            if (fall) begin
              shift_q <= {dat_s2, shift_q[10:1]};
              cnt_q   <= cnt_q + 4'd1;
            end
            // A completing 11th bit wins over a timeout on the same tick.
            if (fall && cnt_q == 4'd10) begin
              state_q <= StCheck;
            end else if (tmo_q == TmoW'(TIMEOUT_TICKS - 1)) begin
              frame_err <= 1'b1;
              ext_q     <= 1'b0;
              brk_q     <= 1'b0;
              state_q   <= StIdle;
            end
          end
          StCheck: begin
            if (!frame_ok) begin
              frame_err <= 1'b1;
              ext_q     <= 1'b0;
              brk_q     <= 1'b0;
            end else if (code == 8'hE0) begin
              ext_q <= 1'b1;
            end else if (code == 8'hF0) begin
              brk_q <= 1'b1;
            end else begin
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign full    = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign pop     = ev.ev_valid && ev.ev_ready;
  assign do_push = push && (!full || pop);

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_q] <= {ext_q, brk_q, code};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (do_push) begin
        wr_q <= wr_q + PtrW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PtrW'(1);
      end
      case ({do_push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign ev.ev_valid = (count_q != '0);
  assign ev.ev_code  = ev.ev_valid ? mem[rd_q][7:0] : 8'h00;
  assign ev.ev_brk   = ev.ev_valid ? mem[rd_q][8]   : 1'b0;
  assign ev.ev_ext   = ev.ev_valid ? mem[rd_q][9]   : 1'b0;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: table of frames plus timeout, overflow and reset sequences.
module tb_ps2_scan_decoder;
  localparam int unsigned SampleDiv    = 4;
  localparam int unsigned TimeoutTicks = 200;
  localparam int unsigned FifoDepth    = 4;

  logic CLK, RST, PS2_CLK, PS2_DATA;
  logic frame_err, overflow, busy;
  ps2_scan_decoder_if ev_if ();

  ps2_scan_decoder #(
    .SAMPLE_DIV   (SampleDiv),
    .TIMEOUT_TICKS(TimeoutTicks),
    .FIFO_DEPTH   (FifoDepth)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PS2_CLK  (PS2_CLK),
    .PS2_DATA (PS2_DATA),
    .ev       (ev_if),
    .frame_err(frame_err),
    .overflow (overflow),
    .busy     (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int ovf_cnt  = 0;

  always @(negedge CLK) begin
    if (frame_err) err_cnt++;
    if (overflow) ovf_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Bit period is 12 ticks: data set, clock low for 6 ticks, clock high again.
  task automatic send_frame(input logic [7:0] c, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^c) ^ bad_par, c, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = f[i];
      wait_clk(12);
      PS2_CLK = 1'b0;
      wait_clk(24);
      PS2_CLK = 1'b1;
      wait_clk(12);
    end
    PS2_DATA = 1'b1;
  endtask

  task automatic wait_event(input int max, output bit got);
    int k;
    k = 0;
    while (!ev_if.ev_valid && k < max) begin
      wait_clk(1);
      k++;
    end
    got = ev_if.ev_valid;
  endtask

  task automatic pop_one();
    ev_if.ev_ready = 1'b1;
    wait_clk(1);
    ev_if.ev_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad;
    bit         exp_ev;
    bit         exp_ext;
    bit         exp_brk;
    bit         exp_err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    bit got;
    int e0, o0, k;

    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h75, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{8'h72, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    RST = 1'b1;
    PS2_CLK = 1'b1;
    PS2_DATA = 1'b1;
    ev_if.ev_ready = 1'b0;
    wait_clk(5);
    check("rst_ev_valid", ev_if.ev_valid, 0);
    check("rst_ev_code", ev_if.ev_code, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    RST = 1'b0;
    wait_clk(10);

    for (int i = 0; i < 14; i++) begin
      e0 = err_cnt;
      send_frame(vecs[i].code, vecs[i].bad, 11);
      if (vecs[i].exp_ev) begin
        wait_event(200, got);
        check($sformatf("v%0d_valid", i), got, 1);
        check($sformatf("v%0d_code", i), ev_if.ev_code, vecs[i].code);
        check($sformatf("v%0d_ext", i), ev_if.ev_ext, vecs[i].exp_ext);
        check($sformatf("v%0d_brk", i), ev_if.ev_brk, vecs[i].exp_brk);
        wait_clk(8);
        check($sformatf("v%0d_hold", i), ev_if.ev_code, vecs[i].code);
        pop_one();
      end else begin
        wait_clk(60);
      end
      check($sformatf("v%0d_empty", i), ev_if.ev_valid, 0);
      check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].exp_err);
    end

    // Partial frame followed by a silent bus.
    e0 = err_cnt;
    send_frame(8'h6B, 1'b0, 5);
    check("tmo_busy_mid", busy, 1);
    k = 0;
    while (err_cnt == e0 && k < 1200) begin
      wait_clk(1);
      k++;
    end
    wait_clk(20);
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_busy", busy, 0);
    check("tmo_empty", ev_if.ev_valid, 0);
    send_frame(8'h6B, 1'b0, 11);
    wait_event(200, got);
    check("tmo_next_valid", got, 1);
    check("tmo_next_code", ev_if.ev_code, 8'h6B);
    check("tmo_next_err", err_cnt - e0, 1);
    pop_one();

    // Fill the FIFO with the consumer stalled.
    o0 = ovf_cnt;
    e0 = err_cnt;
    for (int c = 1; c <= 5; c++) begin
      send_frame(8'(c), 1'b0, 11);
      wait_clk(60);
      if (c == 4) check("ovf_before", ovf_cnt - o0, 0);
    end
    check("ovf_pulse", ovf_cnt - o0, 1);
    check("ovf_err", err_cnt - e0, 0);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("drain%0d_valid", c), ev_if.ev_valid, 1);
      check($sformatf("drain%0d_code", c), ev_if.ev_code, c);
      pop_one();
    end
    check("drain_empty", ev_if.ev_valid, 0);
    check("drain_code0", ev_if.ev_code, 0);

    // Reset with two queued events and a frame in flight.
    send_frame(8'h11, 1'b0, 11);
    send_frame(8'h22, 1'b0, 11);
    wait_clk(60);
    send_frame(8'h44, 1'b0, 6);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_valid", ev_if.ev_valid, 1);
    RST = 1'b1;
    wait_clk(1);
    check("post_rst_valid", ev_if.ev_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_code", ev_if.ev_code, 0);
    RST = 1'b0;
    wait_clk(10);
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 11);
    wait_event(200, got);
    check("rst_next_valid", got, 1);
    check("rst_next_code", ev_if.ev_code, 8'h1C);
    check("rst_next_ext", ev_if.ev_ext, 0);
    check("rst_next_brk", ev_if.ev_brk, 0);
    pop_one();
    wait_clk(20);
    check("rst_next_err", err_cnt - e0, 0);
    check("rst_next_empty", ev_if.ev_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
